// File: rtl/bus_split_n.sv
// rtl/bus_split_n.sv - 1-to-N Bus request router with in-order response route queue
// Optional BUS_SPLIT_DECERR_EN: unmapped addresses are answered locally with ERR.
package Bus;
    typedef enum logic [1:0] {IDLE = 2'd0, WR = 2'd1, RD = 2'd2} Cmd;
    typedef enum logic [1:0] {NULL = 2'd0, DVA = 2'd1, ERR = 2'd2} Resp;
endpackage

module bus_split_n #(
    parameter int NUM_OUT       = 4,
    parameter int SEL_LSB       = 28,
    parameter int SEL_WIDTH     = $clog2(NUM_OUT),
    parameter int NUM_IN_FLIGHT = 4,
    parameter int ADDR_WIDTH    = 32,
    parameter int DATA_WIDTH    = 32
) (
    input  logic                               Clk,
    input  logic                               Reset,
    input  Bus::Cmd                            m_MCmd,
    input  logic [ADDR_WIDTH-1:0]              m_MAddr,
    input  logic [DATA_WIDTH-1:0]              m_MData,
    input  logic [DATA_WIDTH/8-1:0]            m_MByteEn,
    output logic                               m_SCmdAccept,
    output Bus::Resp                           m_SResp,
    output logic [DATA_WIDTH-1:0]              m_SData,
    input  logic                               m_MRespAccept,
    output Bus::Cmd                            s_MCmd      [NUM_OUT],
    output logic [ADDR_WIDTH-1:0]              s_MAddr     [NUM_OUT],
    output logic [DATA_WIDTH-1:0]              s_MData     [NUM_OUT],
    output logic [DATA_WIDTH/8-1:0]            s_MByteEn   [NUM_OUT],
    input  logic [NUM_OUT-1:0]                 s_SCmdAccept,
    input  Bus::Resp                           s_SResp     [NUM_OUT],
    input  logic [DATA_WIDTH-1:0]              s_SData     [NUM_OUT],
    output logic [NUM_OUT-1:0]                 s_MRespAccept,
    output logic [$clog2(NUM_IN_FLIGHT+1)-1:0] in_flight
);

`ifdef BUS_SPLIT_DECERR_EN
    localparam int TAG_W = $clog2(NUM_OUT + 1);
`else
    localparam int TAG_W = $clog2(NUM_OUT);
`endif
    localparam int CNT_W = $clog2(NUM_IN_FLIGHT + 1);
    localparam int PTR_W = (NUM_IN_FLIGHT > 1) ? $clog2(NUM_IN_FLIGHT) : 1;

    logic [TAG_W-1:0]     tag_q [NUM_IN_FLIGHT];
    logic [PTR_W-1:0]     rd_ptr;
    logic [PTR_W-1:0]     wr_ptr;
    logic [CNT_W-1:0]     count;
    logic [SEL_WIDTH-1:0] sel;
    logic [TAG_W-1:0]     route_idx;
    logic [TAG_W-1:0]     push_tag;
    logic [TAG_W-1:0]     head;
    logic                 mapped;
    logic                 local_err;
    logic                 full;
    logic                 empty;
    logic                 push;
    logic                 pop;

    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
        return (p == PTR_W'(NUM_IN_FLIGHT - 1)) ? '0 : p + 1'b1;
    endfunction

    assign sel       = m_MAddr[SEL_LSB +: SEL_WIDTH];
    assign mapped    = int'(sel) < NUM_OUT;
    assign route_idx = mapped ? TAG_W'(sel) : TAG_W'(NUM_OUT - 1);
`ifdef BUS_SPLIT_DECERR_EN
    assign local_err = !mapped;
    assign push_tag  = local_err ? TAG_W'(NUM_OUT) : route_idx;
`else
    assign local_err = 1'b0;
    assign push_tag  = route_idx;
`endif
    assign full      = (count == CNT_W'(NUM_IN_FLIGHT));
    assign empty     = (count == '0);
    assign head      = tag_q[rd_ptr];
    assign in_flight = count;

    always_comb begin
        m_SCmdAccept = 1'b0;
        for (int i = 0; i < NUM_OUT; i++) begin
            s_MAddr[i]   = m_MAddr;
            s_MData[i]   = m_MData;
            s_MByteEn[i] = m_MByteEn;
            s_MCmd[i]    = Bus::IDLE;
            if (!Reset && !full && !local_err && route_idx == TAG_W'(i))
                s_MCmd[i] = m_MCmd;
        end
        if (!Reset && !full && m_MCmd != Bus::IDLE) begin
            if (local_err)
                m_SCmdAccept = 1'b1;
            for (int i = 0; i < NUM_OUT; i++)
                if (!local_err && route_idx == TAG_W'(i))
                    m_SCmdAccept = s_SCmdAccept[i];
        end
    end

    // Only the head slave is visible to the master; the rest hold their responses.
    always_comb begin
        m_SResp       = Bus::NULL;
        m_SData       = '0;
        s_MRespAccept = '0;
        if (!Reset && !empty) begin
`ifdef BUS_SPLIT_DECERR_EN
            if (head == TAG_W'(NUM_OUT))
                m_SResp = Bus::ERR;
`endif
            for (int i = 0; i < NUM_OUT; i++) begin
                if (head == TAG_W'(i)) begin
                    m_SResp          = s_SResp[i];
                    m_SData          = s_SData[i];
                    s_MRespAccept[i] = m_MRespAccept;
                end
            end
        end
    end

    assign push = (m_MCmd != Bus::IDLE) && m_SCmdAccept;
    assign pop  = (m_SResp != Bus::NULL) && m_MRespAccept;

    always_ff @(posedge Clk) begin
        if (push)
            tag_q[wr_ptr] <= push_tag;
    end

    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else begin
            if (push)
                wr_ptr <= ptr_inc(wr_ptr);
            if (pop)
                rd_ptr <= ptr_inc(rd_ptr);
            if (push && !pop)
                count <= count + 1'b1;
            else if (pop && !push)
                count <= count - 1'b1;
        end
    end

endmodule
